// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-entry skid buffer and
// registered output to decode, with redirect flush and HALT detection.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_pc_q, buf_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_instr_q, out_instr_d;
    logic [15:0] out_pc_q, out_pc_d;
    logic        halted_q, halted_d;

    logic accept;
    logic consume;
    logic out_load_ok;

    assign imem_req    = rst_n && (state_q == FETCH) && !buf_valid_q;
    assign imem_addr   = pc_q;
    assign accept      = imem_req && imem_ready && !redirect;
    assign consume     = out_valid_q && !stall;
    assign out_load_ok = !out_valid_q || consume;

    assign instr       = out_instr_q;
    assign instr_valid = out_valid_q;
    assign pc_out      = out_pc_q;
    assign pc_plus2    = out_pc_q + 16'd2;
    assign halted      = halted_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        halted_d    = halted_q;

        if (redirect) begin
            state_d     = FETCH;
            pc_d        = redirect_pc;
            buf_valid_d = 1'b0;
            out_valid_d = 1'b0;
            halted_d    = 1'b0;
        end else begin
            // A full buffer implies no request, so buffer and response
            // never compete for the output register in the same cycle.
            if (out_load_ok) begin
                if (buf_valid_q) begin
                    out_valid_d = 1'b1;
                    out_instr_d = buf_instr_q;
                    out_pc_d    = buf_pc_q;
                    buf_valid_d = 1'b0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                buf_valid_d = 1'b1;
                buf_instr_d = imem_rdata;
                buf_pc_d    = pc_q;
            end

            if (accept) begin
                pc_d = pc_q + 16'd2;
                if (imem_rdata[15:11] == 5'b00000) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= 16'h0000;
            buf_valid_q <= 1'b0;
            buf_instr_q <= 16'h0800;
            buf_pc_q    <= 16'h0000;
            out_valid_q <= 1'b0;
            out_instr_q <= 16'h0800;
            out_pc_q    <= 16'h0000;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            halted_q    <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed phases push expected
// deliveries, a negedge monitor pops them as decode consumes.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        halted;

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] pc;
        logic [15:0] pc2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc_out     (pc_out),
        .pc_plus2   (pc_plus2),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'h0000: mem = 16'h4000;
            16'h0002: mem = 16'h4101;
            16'h0004: mem = 16'h4202;
            16'h0006: mem = 16'h0000;
            16'h0020: mem = 16'h5020;
            16'h0022: mem = 16'h5122;
            16'h0024: mem = 16'h5224;
            16'h0100: mem = 16'h6100;
            16'hFFFE: mem = 16'h7FFE;
            default:  mem = 16'h4800 ^ a;
        endcase
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] i, input logic [15:0] p,
                        input logic [15:0] p2);
        exp_t e;
        e.ins = i;
        e.pc  = p;
        e.pc2 = p2;
        exp_q.push_back(e);
    endtask

    // Monitor: decode consumes on instr_valid && !stall
    always @(negedge clk) begin
        if (rst_n && instr_valid && !stall) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_delivery: got instr %h pc %h, expected none",
                         instr, pc_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("deliv_instr", instr, e.ins);
                check("deliv_pc", pc_out, e.pc);
                check("deliv_pc2", pc_plus2, e.pc2);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_instr", instr, 16'h0800);
        check("rst_valid", {15'd0, instr_valid}, 16'd0);
        check("rst_pc", pc_out, 16'h0000);
        check("rst_pc2", pc_plus2, 16'h0002);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_req", {15'd0, imem_req}, 16'd0);

        // Stream 0x0000..0x0006, last word is HALT
        tick();
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        #1;
        check("first_req", {15'd0, imem_req}, 16'd1);
        check("first_addr", imem_addr, 16'h0000);
        push(16'h4000, 16'h0000, 16'h0002);
        push(16'h4101, 16'h0002, 16'h0004);
        push(16'h4202, 16'h0004, 16'h0006);
        push(16'h0000, 16'h0006, 16'h0008);
        repeat (6) tick();
        check("halt_halted", {15'd0, halted}, 16'd1);
        check("halt_req", {15'd0, imem_req}, 16'd0);
        check("halt_valid", {15'd0, instr_valid}, 16'd0);

        // Redirect out of HALT, then stall 3 cycles
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect = 1'b0;
        stall    = 1'b1;
        check("redir_halted", {15'd0, halted}, 16'd0);
        check("redir_addr", imem_addr, 16'h0020);
        check("redir_req", {15'd0, imem_req}, 16'd1);
        push(16'h5020, 16'h0020, 16'h0022);
        push(16'h5122, 16'h0022, 16'h0024);
        push(16'h5224, 16'h0024, 16'h0026);
        repeat (2) tick();
        check("stall_req", {15'd0, imem_req}, 16'd0);
        check("stall_instr", instr, 16'h5020);
        check("stall_pc", pc_out, 16'h0020);
        tick();
        check("stall_hold", instr, 16'h5020);
        stall = 1'b0;
        repeat (2) tick();
        imem_ready = 1'b0;
        repeat (2) tick();

        // Redirect in the same cycle as a response
        imem_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect   = 1'b0;
        imem_ready = 1'b0;
        check("flush_valid", {15'd0, instr_valid}, 16'd0);
        check("flush_addr", imem_addr, 16'h0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_addr", imem_addr, 16'h0100);
            check("wait_req", {15'd0, imem_req}, 16'd1);
        end
        push(16'h6100, 16'h0100, 16'h0102);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("after_wait_addr", imem_addr, 16'h0102);
        repeat (2) tick();

        // PC wrap at 0xFFFE
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect   = 1'b0;
        imem_ready = 1'b1;
        push(16'h7FFE, 16'hFFFE, 16'h0000);
        push(16'h4000, 16'h0000, 16'h0002);
        repeat (2) tick();
        imem_ready = 1'b0;
        check("wrap_addr", imem_addr, 16'h0002);
        tick();

        // Fill output and buffer, then pulse reset
        stall      = 1'b1;
        imem_ready = 1'b1;
        repeat (2) tick();
        check("full_valid", {15'd0, instr_valid}, 16'd1);
        check("full_instr", instr, 16'h4101);
        check("full_req", {15'd0, imem_req}, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_instr", instr, 16'h0800);
        check("arst_valid", {15'd0, instr_valid}, 16'd0);
        check("arst_pc", pc_out, 16'h0000);
        check("arst_req", {15'd0, imem_req}, 16'd0);
        check("arst_addr", imem_addr, 16'h0000);
        tick();
        rst_n = 1'b1;
        stall = 1'b0;
        #1;
        check("rel_req", {15'd0, imem_req}, 16'd1);
        check("rel_addr", imem_addr, 16'h0000);
        push(16'h4000, 16'h0000, 16'h0002);
        tick();
        imem_ready = 1'b0;
        repeat (3) tick();
        check("drained", exp_q.size()[15:0], 16'd0);
        check("end_halted", {15'd0, halted}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
